// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline with a multi-cycle execute stall FSM.
// Optional stall/flush perf counters are built when HAZARD_PERF_EN is defined.
module hazard_unit_mc #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MC_LATENCY = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  BranchD,
   input  logic                  JumpD,
   input  logic                  McStartE,
   input  logic                  MemtoRegE,
   input  logic                  RegWriteE,
   input  logic                  MemtoRegM,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic [REG_ADDR_W-1:0] rsD,
   input  logic [REG_ADDR_W-1:0] rtD,
   input  logic [REG_ADDR_W-1:0] rsE,
   input  logic [REG_ADDR_W-1:0] rtE,
   input  logic [REG_ADDR_W-1:0] WriteRegE,
   input  logic [REG_ADDR_W-1:0] WriteRegM,
   input  logic [REG_ADDR_W-1:0] WriteRegW,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushM,
   output logic                  ForwardAD,
   output logic                  ForwardBD,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  McBusy,
   output logic                  McDoneE,
   output logic [CNT_W-1:0]      StallCycles,
   output logic [CNT_W-1:0]      FlushCycles
);

   localparam bit MULTI = (MC_LATENCY > 1);
   localparam logic [7:0] CNT_LOAD = MULTI ? 8'(MC_LATENCY - 2) : 8'd0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [7:0] cnt;
   logic       lwstall, branchstall, hzstall, mcstall;

   function automatic logic [1:0] fwd_e(input logic [REG_ADDR_W-1:0] r);
      if (r != '0 && r == WriteRegM && RegWriteM)      return 2'b10;
      else if (r != '0 && r == WriteRegW && RegWriteW) return 2'b01;
      else                                             return 2'b00;
   endfunction

   always_comb begin
      ForwardAE = fwd_e(rsE);
      ForwardBE = fwd_e(rtE);
      ForwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
      ForwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;
   end

   always_comb begin
      lwstall     = MemtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
      branchstall = BranchD &&
                    ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                     (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == rsD) || (WriteRegM == rtD))));
      hzstall     = lwstall || branchstall;
   end

   // MC terms are forced low while reset is high; the state itself clears on the edge.
   always_comb begin
      mcstall = !reset && (((state == IDLE) && McStartE && MULTI) ||
                           ((state == BUSY) && (cnt != '0)));
      McDoneE = !reset && (((state == IDLE) && McStartE && !MULTI) ||
                           ((state == BUSY) && (cnt == '0)));
      McBusy  = (state == BUSY);
      StallF  = hzstall || mcstall;
      StallD  = hzstall || mcstall;
      StallE  = mcstall;
      FlushM  = mcstall;
      FlushE  = hzstall && !mcstall;
      FlushD  = JumpD && !hzstall && !mcstall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (McStartE && MULTI) begin
               state <= BUSY;
               cnt   <= CNT_LOAD;
            end
            BUSY: if (cnt != '0) cnt <= cnt - 8'd1;
                  else           state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCycles <= '0;
         FlushCycles <= '0;
      end else begin
         if (StallD && (StallCycles != '1))
            StallCycles <= StallCycles + 1'b1;
         if ((FlushE || FlushD || FlushM) && (FlushCycles != '1))
            FlushCycles <= FlushCycles + 1'b1;
      end
   end
`else
   assign StallCycles = '0;
   assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomized bench for hazard_unit_mc checked every cycle against an elapsed-cycle reference model.
module tb_hazard_unit_mc;
   localparam int L  = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset, BranchD, JumpD, McStartE, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
   logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
   logic StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAD, ForwardBD, McBusy, McDoneE;
   logic [1:0] ForwardAE, ForwardBE;
   logic [CW-1:0] StallCycles, FlushCycles;

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 0;

   hazard_unit_mc #(.REG_ADDR_W(5), .MC_LATENCY(L), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .BranchD(BranchD), .JumpD(JumpD), .McStartE(McStartE),
      .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MemtoRegM(MemtoRegM),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
      .FlushM(FlushM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE), .McBusy(McBusy), .McDoneE(McDoneE),
      .StallCycles(StallCycles), .FlushCycles(FlushCycles));

   always #5 clk = ~clk;

   // Model state: an MC op is tracked by how many cycles it has already spent in E.
   bit m_active = 0;
   int m_phase  = 0;
   int m_scnt   = 0;
   int m_fcnt   = 0;

   typedef struct {
      int fae, fbe, fad, fbd, sf, sd, se, fd, fe, fm, busy, done;
   } exp_t;

   function automatic int fwd(input logic [4:0] r);
      if (r != 0 && RegWriteM && r == WriteRegM) return 2;
      if (r != 0 && RegWriteW && r == WriteRegW) return 1;
      return 0;
   endfunction

   function automatic exp_t model();
      exp_t e;
      bit lw, br, hz, mc, act;
      int ph;
      e.fae = fwd(rsE);
      e.fbe = fwd(rtE);
      e.fad = int'(rsD != 0 && RegWriteM && rsD == WriteRegM);
      e.fbd = int'(rtD != 0 && RegWriteM && rtD == WriteRegM);
      lw = MemtoRegE && rtE != 0 && (rsD == rtE || rtD == rtE);
      br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == rsD || WriteRegE == rtD)) ||
                       (MemtoRegM && WriteRegM != 0 && (WriteRegM == rsD || WriteRegM == rtD)));
      hz = lw || br;
      act = m_active || McStartE;
      ph  = m_active ? m_phase : 0;
      mc  = !reset && act && (ph < L - 1);
      e.done = int'(!reset && act && (ph == L - 1));
      e.sf = int'(hz || mc);
      e.sd = e.sf;
      e.se = int'(mc);
      e.fm = int'(mc);
      e.fe = int'(hz && !mc);
      e.fd = int'(JumpD && !hz && !mc);
      e.busy = int'(m_active);
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   exp_t ue;
   always @(posedge clk) begin
      ue = model();
      if (reset) begin
         m_active = 0; m_phase = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         if (m_active || McStartE) begin
            m_phase  = (m_active ? m_phase : 0) + 1;
            m_active = (m_phase < L);
         end
         if (ue.sd != 0 && m_scnt < CMAX) m_scnt++;
         if ((ue.fe | ue.fd | ue.fm) != 0 && m_fcnt < CMAX) m_fcnt++;
      end
   end

   exp_t ce;
   always @(negedge clk) begin
      if (chk_en) begin
         ce = model();
         chk("ForwardAE", int'(ForwardAE), ce.fae);
         chk("ForwardBE", int'(ForwardBE), ce.fbe);
         chk("ForwardAD", int'(ForwardAD), ce.fad);
         chk("ForwardBD", int'(ForwardBD), ce.fbd);
         chk("StallF", int'(StallF), ce.sf);
         chk("StallD", int'(StallD), ce.sd);
         chk("StallE", int'(StallE), ce.se);
         chk("FlushD", int'(FlushD), ce.fd);
         chk("FlushE", int'(FlushE), ce.fe);
         chk("FlushM", int'(FlushM), ce.fm);
         chk("McDoneE", int'(McDoneE), ce.done);
         if (!reset) chk("McBusy", int'(McBusy), ce.busy);
`ifdef HAZARD_PERF_EN
         chk("StallCycles", int'(StallCycles), m_scnt);
         chk("FlushCycles", int'(FlushCycles), m_fcnt);
`else
         chk("StallCycles", int'(StallCycles), 0);
         chk("FlushCycles", int'(FlushCycles), 0);
`endif
      end
   end

   task automatic clear();
      {BranchD, JumpD, McStartE, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW} = '0;
      {rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW} = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] rreg();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
   endfunction

   initial begin
      clear();
      reset = 1'b1;
      step(); step();
      chk_en = 1;
      reset = 1'b0;
      chk("reset McBusy", int'(McBusy), 0);

      // Forwarding priority
      rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
      #2 chk("fwd M prio", int'(ForwardAE), 2);
      step(); RegWriteM = 1'b0;
      #2 chk("fwd W", int'(ForwardAE), 1);
      step(); rsE = 5'd0;
      #2 chk("fwd r0", int'(ForwardAE), 0);

      // Load-use
      step(); clear(); MemtoRegE = 1'b1; RegWriteE = 1'b1; rtE = 5'd7; rsD = 5'd7;
      #2 chk("lw StallD", int'(StallD), 1); chk("lw FlushE", int'(FlushE), 1);
      chk("lw StallE", int'(StallE), 0); chk("lw FlushM", int'(FlushM), 0);
      step(); MemtoRegE = 1'b0;
      #2 chk("lw clear StallF", int'(StallF), 0); chk("lw clear FlushE", int'(FlushE), 0);

      // Branch and jump
      step(); clear(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rsD = 5'd5;
      #2 chk("br StallD", int'(StallD), 1); chk("br FlushE", int'(FlushE), 1);
      step(); clear(); JumpD = 1'b1; rsD = 5'd1;
      #2 chk("jmp FlushD", int'(FlushD), 1); chk("jmp StallF", int'(StallF), 0);

      // MC op, with a load-use hazard during its second cycle
      step(); clear(); McStartE = 1'b1;
      #2 chk("mc t StallE", int'(StallE), 1); chk("mc t McBusy", int'(McBusy), 0);
      step(); MemtoRegE = 1'b1; rtE = 5'd7; rsD = 5'd7;
      #2 chk("mc t+1 McBusy", int'(McBusy), 1); chk("mc t+1 FlushE", int'(FlushE), 0);
      chk("mc t+1 StallD", int'(StallD), 1);
      step(); MemtoRegE = 1'b0;
      #2 chk("mc t+2 FlushM", int'(FlushM), 1);
      step();
      #2 chk("mc t+3 McDoneE", int'(McDoneE), 1); chk("mc t+3 StallE", int'(StallE), 0);
      chk("mc t+3 McBusy", int'(McBusy), 1);
      step(); McStartE = 1'b0;
      #2 chk("mc t+4 McBusy", int'(McBusy), 0); chk("mc t+4 McDoneE", int'(McDoneE), 0);

      // Reset in the middle of an MC op
      step(); McStartE = 1'b1;
      step(); reset = 1'b1;
      #2 chk("rst McDoneE", int'(McDoneE), 0); chk("rst StallE", int'(StallE), 0);
      step(); reset = 1'b0; McStartE = 1'b0;
      #2 chk("post-rst McBusy", int'(McBusy), 0); chk("post-rst StallE", int'(StallE), 0);
      step();
      #2 chk("post-rst McDoneE", int'(McDoneE), 0);

      // Counter saturation over 20 load-use cycles
      step(); reset = 1'b1;
      step(); reset = 1'b0; MemtoRegE = 1'b1; rtE = 5'd9; rtD = 5'd9;
      repeat (20) step();
      clear();
`ifdef HAZARD_PERF_EN
      #2 chk("StallCycles sat", int'(StallCycles), CMAX);
`else
      #2 chk("StallCycles off", int'(StallCycles), 0);
`endif
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      #2 chk("StallCycles reset", int'(StallCycles), 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step();
         reset     = ($urandom_range(0, 99) == 0);
         BranchD   = ($urandom_range(0, 3) == 0);
         JumpD     = ($urandom_range(0, 4) == 0);
         McStartE  = ($urandom_range(0, 2) == 0);
         MemtoRegE = ($urandom_range(0, 3) == 0);
         RegWriteE = $urandom_range(0, 1);
         MemtoRegM = ($urandom_range(0, 3) == 0);
         RegWriteM = $urandom_range(0, 1);
         RegWriteW = $urandom_range(0, 1);
         rsD = rreg(); rtD = rreg(); rsE = rreg(); rtE = rreg();
         WriteRegE = rreg(); WriteRegM = rreg(); WriteRegW = rreg();
      end
      step();
      clear(); reset = 1'b0;
      step(); step();
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
